// File: rtl/if_stage.sv
// Instruction fetch stage: owns the PC, issues one word fetch at a time,
// buffers returned words with their PCs and hands them to decode.
module if_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    input  logic        stall_i,
    output logic        instr_valid_o,
    output logic [31:0] instruction_o,
    output logic [31:0] pc_o,
    output logic        misalign_o
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);
    localparam logic [31:0] NOP = 32'h0000_0013;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [31:0]   req_addr_q;
    logic          drop_q, drop_d;
    logic          misalign_q;

    logic [31:0]   pc_mem  [FIFO_DEPTH];
    logic [31:0]   ins_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q, count_d;

    logic          push, pop;
    logic [31:0]   redir_pc;

    assign redir_pc = {redirect_pc_i[31:2], 2'b00};

    assign instr_valid_o = (count_q != '0);
    assign instruction_o = instr_valid_o ? ins_mem[rd_ptr_q] : NOP;
    assign pc_o          = instr_valid_o ? pc_mem[rd_ptr_q] : 32'h0;
    assign imem_req_o    = (state_q == S_REQ);
    assign imem_addr_o   = req_addr_q;
    assign misalign_o    = misalign_q;

    // A redirect cancels both the write of a response and the read by decode.
    assign push = (state_q == S_WAIT) && imem_rvalid_i
                  && !drop_q && !redirect_i;
    assign pop  = instr_valid_o && !stall_i && !redirect_i;

    // Next occupancy, PC and fetch FSM transitions.
    always_comb begin
        count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
        pc_d    = pc_q;
        state_d = state_q;
        drop_d  = drop_q;

        if (redirect_i) begin
            count_d = '0;
        end

        // A dropped request was already fetching a stale address,
        // so its grant must not advance the PC.
        if (redirect_i) begin
            pc_d = redir_pc;
        end else if (state_q == S_REQ && imem_gnt_i && !drop_q) begin
            pc_d = pc_q + 32'd4;
        end

        unique case (state_q)
            S_IDLE: begin
                if (count_d < DEPTH_C) state_d = S_REQ;
            end
            S_REQ: begin
                if (imem_gnt_i) state_d = S_WAIT;
                if (redirect_i) drop_d = 1'b1;
            end
            S_WAIT: begin
                if (imem_rvalid_i) begin
                    drop_d  = 1'b0;
                    state_d = (count_d < DEPTH_C) ? S_REQ : S_IDLE;
                end else if (redirect_i) begin
                    drop_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM, PC, request address and status flags.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            req_addr_q <= RESET_PC;
            drop_q     <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            drop_q     <= drop_d;
            misalign_q <= redirect_i && (redirect_pc_i[1:0] != 2'b00);
            if (state_d == S_REQ && state_q != S_REQ) begin
                req_addr_q <= pc_d;
            end
        end
    end

    // Instruction buffer pointers and occupancy.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            count_q <= count_d;
            if (redirect_i) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
                if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    // Instruction buffer storage; contents are qualified by occupancy.
    always_ff @(posedge clk_i) begin
        if (push) begin
            pc_mem[wr_ptr_q]  <= req_addr_q;
            ins_mem[wr_ptr_q] <= imem_rdata_i;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: reset, streaming, stall back-pressure,
// redirects (dropped and coincident responses) and PC wrap-around.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req, gnt, rvalid;
    logic [31:0] addr, rdata;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        stall = 1'b0;
    logic        valid, misalign;
    logic [31:0] instr, pc;

    logic        gnt_en = 1'b1;
    logic        rv_en = 1'b1;
    logic        pend;
    logic [31:0] paddr;

    logic        rst2_n = 1'b0;
    logic        req2, gnt2, rvalid2, valid2, misalign2;
    logic [31:0] addr2, rdata2, instr2, pc2;
    logic        pend2;
    logic [31:0] paddr2;
    logic [31:0] log2[$];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    if_stage u_dut (
        .clk_i(clk), .rst_ni(rst_n),
        .imem_req_o(req), .imem_addr_o(addr),
        .imem_gnt_i(gnt), .imem_rvalid_i(rvalid), .imem_rdata_i(rdata),
        .redirect_i(redirect), .redirect_pc_i(redirect_pc),
        .stall_i(stall), .instr_valid_o(valid),
        .instruction_o(instr), .pc_o(pc), .misalign_o(misalign)
    );

    if_stage #(.RESET_PC(32'hFFFF_FFF8)) u_wrap (
        .clk_i(clk), .rst_ni(rst2_n),
        .imem_req_o(req2), .imem_addr_o(addr2),
        .imem_gnt_i(gnt2), .imem_rvalid_i(rvalid2), .imem_rdata_i(rdata2),
        .redirect_i(1'b0), .redirect_pc_i(32'h0),
        .stall_i(1'b0), .instr_valid_o(valid2),
        .instruction_o(instr2), .pc_o(pc2), .misalign_o(misalign2)
    );

    // Memory model: grant in the request cycle, data once released.
    assign gnt    = req && gnt_en;
    assign rvalid = pend && rv_en;
    assign rdata  = paddr | 32'h100;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend  <= 1'b0;
            paddr <= 32'h0;
        end else if (req && gnt) begin
            pend  <= 1'b1;
            paddr <= addr;
        end else if (rvalid) begin
            pend <= 1'b0;
        end
    end

    // Zero-wait memory for the wrap-around instance, logging grants.
    assign gnt2    = req2;
    assign rvalid2 = pend2;
    assign rdata2  = paddr2 | 32'h100;
    always @(posedge clk or negedge rst2_n) begin
        if (!rst2_n) begin
            pend2  <= 1'b0;
            paddr2 <= 32'h0;
        end else if (req2 && gnt2) begin
            pend2  <= 1'b1;
            paddr2 <= addr2;
        end else if (rvalid2) begin
            pend2 <= 1'b0;
        end
    end
    always @(posedge clk) begin
        if (rst2_n && req2 && gnt2) log2.push_back(addr2);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (!valid && n < 20) begin
            step();
            n++;
        end
        chk({tag, "_timeout"}, 32'(valid), 32'd1);
    endtask

    initial begin
        // Reset values
        step();
        step();
        chk("rst_req", 32'(req), 32'd0);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_instr", instr, 32'h13);
        chk("rst_pc", pc, 32'h0);
        chk("rst_mis", 32'(misalign), 32'd0);
        chk("rst_addr", addr, 32'h0);
        rst_n = 1'b1;
        step();
        chk("first_req", 32'(req), 32'd1);
        chk("first_addr", addr, 32'h0);
        step();
        // Reset asserted while waiting for the response
        rst_n = 1'b0;
        #1;
        chk("midwait_req", 32'(req), 32'd0);
        chk("midwait_valid", 32'(valid), 32'd0);
        chk("midwait_instr", instr, 32'h13);

        // Zero-wait streaming: one instruction every two cycles
        do_reset();
        step();
        chk("z_addr0", addr, 32'h0);
        step();
        step();
        chk("z_v0", 32'(valid), 32'd1);
        chk("z_pc0", pc, 32'h0);
        chk("z_i0", instr, 32'h100);
        step();
        chk("z_gap0", 32'(valid), 32'd0);
        step();
        chk("z_pc4", pc, 32'h4);
        chk("z_i4", instr, 32'h104);
        step();
        chk("z_gap1", 32'(valid), 32'd0);
        step();
        chk("z_pc8", pc, 32'h8);
        chk("z_i8", instr, 32'h108);
        step();
        step();
        chk("z_pc12", pc, 32'hC);
        chk("z_i12", instr, 32'h10C);

        // Stall: buffer fills to depth, then requests stop
        stall = 1'b1;
        do_reset();
        repeat (10) step();
        chk("st_req", 32'(req), 32'd0);
        chk("st_valid", 32'(valid), 32'd1);
        chk("st_pc0", pc, 32'h0);
        repeat (3) step();
        chk("st_hold_req", 32'(req), 32'd0);
        chk("st_hold_pc", pc, 32'h0);
        stall = 1'b0;
        #1;
        chk("st_out0", pc, 32'h0);
        step();
        chk("st_v4", 32'(valid), 32'd1);
        chk("st_out4", pc, 32'h4);
        step();
        wait_valid("st_w8");
        chk("st_out8", pc, 32'h8);
        chk("st_i8", instr, 32'h108);

        // Redirect while waiting on address 0x8
        do_reset();
        repeat (5) step();
        chk("rd_addr8", addr, 32'h8);
        rv_en = 1'b0;
        step();
        chk("rd_wait", 32'(req), 32'd0);
        redirect = 1'b1;
        redirect_pc = 32'h200;
        step();
        redirect = 1'b0;
        rv_en = 1'b1;
        #1;
        chk("rd_v_a", 32'(valid), 32'd0);
        chk("rd_mis", 32'(misalign), 32'd0);
        step();
        chk("rd_v_b", 32'(valid), 32'd0);
        chk("rd_req", 32'(req), 32'd1);
        chk("rd_addr", addr, 32'h200);
        step();
        chk("rd_v_c", 32'(valid), 32'd0);
        step();
        chk("rd_v", 32'(valid), 32'd1);
        chk("rd_pc", pc, 32'h200);
        chk("rd_instr", instr, 32'h300);

        // Misaligned redirect coincident with the response
        do_reset();
        step();
        step();
        chk("ma_rvalid", 32'(rvalid), 32'd1);
        redirect = 1'b1;
        redirect_pc = 32'h203;
        step();
        redirect = 1'b0;
        #1;
        chk("ma_pulse", 32'(misalign), 32'd1);
        chk("ma_valid", 32'(valid), 32'd0);
        chk("ma_req", 32'(req), 32'd1);
        chk("ma_addr", addr, 32'h200);
        step();
        chk("ma_pulse_end", 32'(misalign), 32'd0);
        step();
        chk("ma_v", 32'(valid), 32'd1);
        chk("ma_pc", pc, 32'h200);
        chk("ma_instr", instr, 32'h300);

        // PC wrap-around from RESET_PC = FFFF_FFF8
        rst2_n = 1'b1;
        repeat (12) step();
        chk("wr_count", 32'(log2.size() >= 4), 32'd1);
        if (log2.size() >= 4) begin
            chk("wr_a0", log2[0], 32'hFFFF_FFF8);
            chk("wr_a1", log2[1], 32'hFFFF_FFFC);
            chk("wr_a2", log2[2], 32'h0000_0000);
            chk("wr_a3", log2[3], 32'h0000_0004);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
